// File: rtl/commit_scoreboard.sv
// Ordered commit checker: a golden model queues expected retire records and the
// DUT's retire stream is compared against them one-for-one until halt, mismatch or timeout.
module commit_scoreboard #(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int RAW         = 5,
   parameter int DEPTH       = 8,
   parameter int MAX_COMMITS = 100,
   parameter int MAX_IDLE    = 16,
   localparam int CW         = $clog2(MAX_COMMITS + 1)
) (
   input  logic           clk_i,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic           exp_valid_i,
   output logic           exp_ready_o,
   input  logic [AW-1:0]  exp_pc_i,
   input  logic           exp_we_i,
   input  logic [RAW-1:0] exp_waddr_i,
   input  logic [DW-1:0]  exp_wdata_i,
   input  logic           exp_halt_i,
   input  logic           dut_valid_i,
   input  logic [AW-1:0]  dut_pc_i,
   input  logic           dut_we_i,
   input  logic [RAW-1:0] dut_waddr_i,
   input  logic [DW-1:0]  dut_wdata_i,
   output logic           busy_o,
   output logic           pass_o,
   output logic           fail_o,
   output logic           timeout_o,
   output logic [2:0]     err_code_o,
   output logic [CW-1:0]  err_index_o,
   output logic [CW-1:0]  commit_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int NW = PW + 1;
   localparam int IW = $clog2(MAX_IDLE + 1);

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_PC    = 3'd1;
   localparam logic [2:0] E_WE    = 3'd2;
   localparam logic [2:0] E_WADDR = 3'd3;
   localparam logic [2:0] E_WDATA = 3'd4;
   localparam logic [2:0] E_UFLOW = 3'd5;

   typedef struct packed {
      logic [AW-1:0]  pc;
      logic           we;
      logic [RAW-1:0] waddr;
      logic [DW-1:0]  wdata;
      logic           halt;
   } rec_t;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

   state_t         state, state_nx;
   rec_t           mem [DEPTH];
   rec_t           head, in_rec;
   logic [PW-1:0]  wr_ptr, rd_ptr, wr_idx;
   logic [NW-1:0]  count;
   logic [IW-1:0]  idle_cnt;
   logic [CW-1:0]  commit_cnt, err_index;
   logic [2:0]     err_code, chk_code;
   logic           full, empty, terminal, push, pop, commit, idle_hit, last_commit;

   assign full        = (count == NW'(DEPTH));
   assign empty       = (count == '0);
   assign terminal    = (state == S_PASS) || (state == S_FAIL) || (state == S_TMO);
   assign exp_ready_o = !full && !terminal;
   assign push        = exp_valid_i && exp_ready_o;
   assign commit      = (state == S_RUN) && dut_valid_i && !start_i;
   assign pop         = commit && !empty;
   assign head        = mem[rd_ptr];
   assign in_rec      = '{pc: exp_pc_i, we: exp_we_i, waddr: exp_waddr_i,
                          wdata: exp_wdata_i, halt: exp_halt_i};
   // A restart flushes the FIFO, so a record accepted on that same edge lands in slot 0.
   assign wr_idx      = start_i ? '0 : wr_ptr;
   assign idle_hit    = (state == S_RUN) && !dut_valid_i && !start_i &&
                        (idle_cnt == IW'(MAX_IDLE - 1));
   assign last_commit = (commit_cnt == CW'(MAX_COMMITS - 1));

   // Ordered checks: the first disagreement decides the error class.
   always_comb begin
      chk_code = E_NONE;
      if (head.pc != dut_pc_i)
         chk_code = E_PC;
      else if (head.we != dut_we_i)
         chk_code = E_WE;
      else if (head.we && (head.waddr != dut_waddr_i))
         chk_code = E_WADDR;
      else if (head.we && (head.waddr != '0) && (head.wdata != dut_wdata_i))
         chk_code = E_WDATA;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start_i) state_nx = S_RUN;
         S_RUN: begin
            if (start_i)
               state_nx = S_RUN;
            else if (commit) begin
               if (empty || (chk_code != E_NONE)) state_nx = S_FAIL;
               else if (head.halt)                state_nx = S_PASS;
               else if (last_commit)              state_nx = S_TMO;
            end else if (idle_hit)
               state_nx = S_TMO;
         end
         default: if (start_i) state_nx = S_RUN;
      endcase
   end

   always_comb begin
      busy_o       = (state == S_RUN);
      pass_o       = (state == S_PASS);
      fail_o       = (state == S_FAIL);
      timeout_o    = (state == S_TMO);
      err_code_o   = err_code;
      err_index_o  = err_index;
      commit_cnt_o = commit_cnt;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (start_i) begin
         rd_ptr <= '0;
         wr_ptr <= push ? PW'(1) : '0;
         count  <= push ? NW'(1) : '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + NW'(1);
            2'b01:   count <= count - NW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_idx] <= in_rec;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt   <= '0;
         commit_cnt <= '0;
         err_code   <= E_NONE;
         err_index  <= '0;
      end else if (start_i) begin
         idle_cnt   <= '0;
         commit_cnt <= '0;
         err_code   <= E_NONE;
         err_index  <= '0;
      end else if (commit) begin
         idle_cnt <= '0;
         if (empty) begin
            err_code  <= E_UFLOW;
            err_index <= commit_cnt;
         end else if (chk_code != E_NONE) begin
            err_code  <= chk_code;
            err_index <= commit_cnt;
         end else if (commit_cnt != CW'(MAX_COMMITS)) begin
            commit_cnt <= commit_cnt + CW'(1);
         end
      end else if ((state == S_RUN) && (idle_cnt != IW'(MAX_IDLE))) begin
         idle_cnt <= idle_cnt + IW'(1);
      end
   end

endmodule
